// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/hazard controller ahead of the EX-stage ALU
//
// Decodes the ID opcode, checks RAW/WAW hazards against a 32-entry pending
// scoreboard, holds issue while a branch/jump resolves and flushes on taken
// branches. Optional performance counters: define ALU_ISSUE_PERF_CNT_EN.
//
// Ports:
//   clk, reset         clock; synchronous active-low reset
//   id_valid/id_op/id_rs_add/id_rt_add/id_rd_add   ID-stage instruction
//   id_ready           combinational; issue when id_valid && id_ready
//   ex_valid/ex_op/ex_dst_add/ex_dst_wr            registered issue to EX
//   ex_br_taken        branch outcome, sampled in the branch-wait cycle
//   wb_valid/wb_rd_add retiring register write
//   flush              registered one-cycle kill pulse for IF/ID
//   halted             high once HALT has issued, until reset
//   pending            scoreboard, one bit per register
//   perf_issued/perf_stall/perf_flush  saturating counters (macro only)

module alu_issue_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter bit WB_BYPASS    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [5:0]  id_op,
    input  logic [4:0]  id_rs_add,
    input  logic [4:0]  id_rt_add,
    input  logic [4:0]  id_rd_add,
    output logic        id_ready,
    output logic        ex_valid,
    output logic [5:0]  ex_op,
    output logic [4:0]  ex_dst_add,
    output logic        ex_dst_wr,
    input  logic        ex_br_taken,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd_add,
    output logic        flush,
    output logic        halted,
`ifdef ALU_ISSUE_PERF_CNT_EN
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    output logic [31:0] pending
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_BR_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_HALTED  = 2'd3;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    logic [1:0]  state;
    logic [2:0]  flush_cnt;
    logic        br_is_jr;

    logic        rd_rs;
    logic        rd_rt;
    logic        wr;
    logic [4:0]  dst;
    logic        is_br;
    logic        is_jr;
    logic        is_halt;

    logic [31:0] wb_mask;
    logic [31:0] pend_eff;
    logic [31:0] set_mask;
    logic        hazard;
    logic        issue;

    always_comb begin
        rd_rs   = 1'b0;
        rd_rt   = 1'b0;
        wr      = 1'b0;
        dst     = 5'd0;
        is_br   = 1'b0;
        is_jr   = 1'b0;
        is_halt = 1'b0;
        if (id_op <= 6'b001011) begin
            // Register ALU ops are even; their immediate forms are the odd neighbours.
            rd_rs = 1'b1;
            wr    = 1'b1;
            if (!id_op[0]) begin
                rd_rt = 1'b1;
                dst   = id_rd_add;
            end else begin
                dst   = id_rt_add;
            end
        end else begin
            case (id_op)
                6'b001100: begin rd_rs = 1'b1; wr = 1'b1; dst = id_rt_add; end
                6'b001101: begin rd_rs = 1'b1; rd_rt = 1'b1; end
                6'b001110: begin rd_rs = 1'b1; is_br = 1'b1; end
                6'b001111: begin rd_rs = 1'b1; rd_rt = 1'b1; is_br = 1'b1; end
                6'b010000: begin rd_rs = 1'b1; is_br = 1'b1; is_jr = 1'b1; end
                6'b010001: is_halt = 1'b1;
                default:   ;
            endcase
        end
    end

    // A register retiring this very cycle is not a hazard when bypassing is on.
    assign wb_mask  = wb_valid ? (32'd1 << wb_rd_add) : 32'd0;
    assign pend_eff = pending & ~(WB_BYPASS ? wb_mask : 32'd0);

    assign hazard = (rd_rs && pend_eff[id_rs_add]) ||
                    (rd_rt && pend_eff[id_rt_add]) ||
                    (wr    && pend_eff[dst]);

    assign id_ready = (state == S_RUN) && !hazard;
    assign issue    = id_valid && id_ready;
    assign set_mask = (issue && wr) ? (32'd1 << dst) : 32'd0;
    assign halted   = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_RUN;
            flush_cnt  <= 3'd0;
            br_is_jr   <= 1'b0;
            pending    <= 32'd0;
            ex_valid   <= 1'b0;
            ex_op      <= 6'd0;
            ex_dst_add <= 5'd0;
            ex_dst_wr  <= 1'b0;
            flush      <= 1'b0;
        end else begin
            // Issue set is OR'ed after the writeback clear so the set wins.
            pending  <= (pending & ~wb_mask) | set_mask;
            ex_valid <= issue;
            if (issue) begin
                ex_op      <= id_op;
                ex_dst_add <= dst;
                ex_dst_wr  <= wr;
            end
            flush <= 1'b0;
            case (state)
                S_RUN: begin
                    if (issue) begin
                        if (is_halt) begin
                            state <= S_HALTED;
                        end else if (is_br) begin
                            state    <= S_BR_WAIT;
                            br_is_jr <= is_jr;
                        end
                    end
                end
                S_BR_WAIT: begin
                    if (ex_br_taken || br_is_jr) begin
                        flush     <= 1'b1;
                        state     <= S_FLUSH;
                        flush_cnt <= FLUSH_INIT;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state <= S_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= S_HALTED;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic flush_set;
    assign flush_set = (state == S_BR_WAIT) && (ex_br_taken || br_is_jr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_issued <= 32'd0;
            perf_stall  <= 32'd0;
            perf_flush  <= 32'd0;
        end else begin
            if (issue && perf_issued != 32'hFFFFFFFF)
                perf_issued <= perf_issued + 32'd1;
            if (id_valid && !id_ready && state == S_RUN && perf_stall != 32'hFFFFFFFF)
                perf_stall <= perf_stall + 32'd1;
            if (flush_set && perf_flush != 32'hFFFFFFFF)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_op;
    logic [4:0]  id_rs_add;
    logic [4:0]  id_rt_add;
    logic [4:0]  id_rd_add;
    logic        id_ready;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [4:0]  ex_dst_add;
    logic        ex_dst_wr;
    logic        ex_br_taken;
    logic        wb_valid;
    logic [4:0]  wb_rd_add;
    logic        flush;
    logic        halted;
    logic [31:0] pending;
`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl #(.FLUSH_CYCLES(2), .WB_BYPASS(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_op       (id_op),
        .id_rs_add   (id_rs_add),
        .id_rt_add   (id_rt_add),
        .id_rd_add   (id_rd_add),
        .id_ready    (id_ready),
        .ex_valid    (ex_valid),
        .ex_op       (ex_op),
        .ex_dst_add  (ex_dst_add),
        .ex_dst_wr   (ex_dst_wr),
        .ex_br_taken (ex_br_taken),
        .wb_valid    (wb_valid),
        .wb_rd_add   (wb_rd_add),
        .flush       (flush),
        .halted      (halted),
`ifdef ALU_ISSUE_PERF_CNT_EN
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush),
`endif
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and settle the combinational path.
    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_op     = op;
        id_rs_add = rs;
        id_rt_add = rt;
        id_rd_add = rd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic wb(input logic v, input logic [4:0] a);
        wb_valid  = v;
        wb_rd_add = a;
    endtask

    initial begin
        reset = 1'b0;
        ex_br_taken = 1'b0;
        wb(1'b0, 5'd0);
        idle();
        tick();
        tick();
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_op", {26'd0, ex_op}, 32'd0);
        check("rst_ex_dst", {27'd0, ex_dst_add}, 32'd0);
        check("rst_ex_wr", {31'd0, ex_dst_wr}, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;

        // ADD r3 = r1 + r2
        drive(1'b1, 6'b000000, 5'd1, 5'd2, 5'd3);
        check("add_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("add_ex_valid", {31'd0, ex_valid}, 32'd1);
        check("add_ex_dst", {27'd0, ex_dst_add}, 32'd3);
        check("add_ex_wr", {31'd0, ex_dst_wr}, 32'd1);
        check("add_pending", pending, 32'h8);

        // SUB r6 = r3 - r4 stalls on r3
        drive(1'b1, 6'b000010, 5'd3, 5'd4, 5'd6);
        check("sub_stall0", {31'd0, id_ready}, 32'd0);
        tick();
        check("sub_stall_ex", {31'd0, ex_valid}, 32'd0);
        check("sub_stall_hold_dst", {27'd0, ex_dst_add}, 32'd3);
        check("sub_stall1", {31'd0, id_ready}, 32'd0);
        tick();
        wb(1'b1, 5'd3);
        #1;
        check("sub_bypass_ready", {31'd0, id_ready}, 32'd1);
        tick();
        wb(1'b0, 5'd0);
        check("sub_ex_valid", {31'd0, ex_valid}, 32'd1);
        check("sub_ex_op", {26'd0, ex_op}, 32'h2);
        check("sub_ex_dst", {27'd0, ex_dst_add}, 32'd6);
        check("sub_pending", pending, 32'h40);

        // retire r6
        idle();
        wb(1'b1, 5'd6);
        tick();
        wb(1'b0, 5'd0);
        check("wb6_pending", pending, 32'd0);

        // BEQ taken: flush pulse, three cycles not ready
        drive(1'b1, 6'b001111, 5'd1, 5'd2, 5'd0);
        check("beq_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("beq_ex_wr", {31'd0, ex_dst_wr}, 32'd0);
        check("beq_pending", pending, 32'd0);
        drive(1'b1, 6'b000000, 5'd1, 5'd2, 5'd7);
        ex_br_taken = 1'b1;
        check("beq_wait_ready", {31'd0, id_ready}, 32'd0);
        tick();
        ex_br_taken = 1'b0;
        check("beq_flush", {31'd0, flush}, 32'd1);
        check("beq_fl1_ready", {31'd0, id_ready}, 32'd0);
        tick();
        check("beq_flush_off", {31'd0, flush}, 32'd0);
        check("beq_fl2_ready", {31'd0, id_ready}, 32'd0);
        check("beq_fl2_exv", {31'd0, ex_valid}, 32'd0);
        tick();
        check("beq_run_ready", {31'd0, id_ready}, 32'd1);
        idle();

        // BZ not taken
        drive(1'b1, 6'b001110, 5'd1, 5'd0, 5'd0);
        tick();
        idle();
        check("bz_wait_ready", {31'd0, id_ready}, 32'd0);
        tick();
        check("bz_no_flush", {31'd0, flush}, 32'd0);
        check("bz_run_ready", {31'd0, id_ready}, 32'd1);

        // JR always flushes
        drive(1'b1, 6'b010000, 5'd1, 5'd0, 5'd0);
        tick();
        idle();
        tick();
        check("jr_flush", {31'd0, flush}, 32'd1);
        tick();
        tick();
        check("jr_run_ready", {31'd0, id_ready}, 32'd1);

        // ADD r5, then ADDI r5 concurrently with wb of r5: set wins
        drive(1'b1, 6'b000000, 5'd1, 5'd2, 5'd5);
        tick();
        check("add5_pending", pending, 32'h20);
        drive(1'b1, 6'b000001, 5'd1, 5'd5, 5'd0);
        wb(1'b1, 5'd5);
        #1;
        check("addi_waw_bypass", {31'd0, id_ready}, 32'd1);
        tick();
        wb(1'b0, 5'd0);
        check("addi_ex_dst", {27'd0, ex_dst_add}, 32'd5);
        check("addi_set_wins", pending, 32'h20);

        // unknown opcode issues as a NOP
        drive(1'b1, 6'b111111, 5'd5, 5'd5, 5'd5);
        check("nop_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("nop_ex_wr", {31'd0, ex_dst_wr}, 32'd0);
        check("nop_pending", pending, 32'h20);

        // reset in BR_WAIT
        drive(1'b1, 6'b001111, 5'd1, 5'd2, 5'd0);
        tick();
        idle();
        ex_br_taken = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ex_br_taken = 1'b0;
        check("rstbr_flush", {31'd0, flush}, 32'd0);
        check("rstbr_pending", pending, 32'd0);
        check("rstbr_exv", {31'd0, ex_valid}, 32'd0);
        check("rstbr_ready", {31'd0, id_ready}, 32'd1);

        // reset in FLUSH
        drive(1'b1, 6'b010000, 5'd1, 5'd0, 5'd0);
        tick();
        idle();
        tick();
        check("rstfl_pre_flush", {31'd0, flush}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rstfl_flush", {31'd0, flush}, 32'd0);
        check("rstfl_ready", {31'd0, id_ready}, 32'd1);
`ifdef ALU_ISSUE_PERF_CNT_EN
        check("rstfl_perf_issued", perf_issued, 32'd0);
        check("rstfl_perf_stall", perf_stall, 32'd0);
        check("rstfl_perf_flush", perf_flush, 32'd0);
`endif

        // ADD r9 then HALT; writeback still retires while halted
        drive(1'b1, 6'b000000, 5'd1, 5'd2, 5'd9);
        tick();
        drive(1'b1, 6'b010001, 5'd0, 5'd0, 5'd0);
        tick();
        check("halt_halted", {31'd0, halted}, 32'd1);
        drive(1'b1, 6'b000000, 5'd1, 5'd2, 5'd4);
        check("halt_ready", {31'd0, id_ready}, 32'd0);
        wb(1'b1, 5'd9);
        tick();
        wb(1'b0, 5'd0);
        check("halt_wb_pending", pending, 32'd0);
        tick();
        check("halt_stays", {31'd0, halted}, 32'd1);
        check("halt_ready2", {31'd0, id_ready}, 32'd0);
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("halt_rst", {31'd0, halted}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue and hazard controller in front of the EX-stage ALU.
- Decodes the ID-stage opcode and tracks in-flight destination registers in a 32-entry scoreboard.
- Stalls ID on RAW and WAW hazards, holds issue while a branch or jump resolves, and flushes on taken branches.
- Drives the EX-stage valid, opcode and destination signals consumed by the ALU and MEM stages.

Parameters:
FLUSH_CYCLES, 2, cycles ID is held in FLUSH after a taken branch/jump (1..7)
WB_BYPASS, 1, 1: a same-cycle writeback to a register counts as not pending for hazard checks

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
id_valid  in  1  ID holds an instruction
id_op  in  6  opcode
id_rs_add  in  5  rs field
id_rt_add  in  5  rt field
id_rd_add  in  5  rd field
id_ready  out  1  combinational; instruction issues this cycle when id_valid && id_ready
ex_valid  out  1  registered issue strobe to EX
ex_op  out  6  registered opcode to EX
ex_dst_add  out  5  registered destination address
ex_dst_wr  out  1  registered: the issued instruction writes a register
ex_br_taken  in  1  EX branch outcome, sampled in the BR_WAIT cycle
wb_valid  in  1  writeback retiring a register write
wb_rd_add  in  5  writeback destination
flush  out  1  registered one-cycle pulse: kill the ID/IF contents
halted  out  1  high in HALTED
pending  out  32  scoreboard bit per register

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=RUN, pending=0, ex_valid=0, ex_op=0, ex_dst_add=0, ex_dst_wr=0, flush=0.
  - Reset overrides every in-flight event, including a pending branch resolution or flush.
- Decode, reads and writes:
  - Even ops 000000..001010 (ADD, SUB, MUL, OR, AND, XOR): read rs,rt; write rd.
  - Odd ops 000001..001011 (immediate forms): read rs; write rt.
  - 001100 LDW: read rs; write rt.
  - 001101 STW: read rs,rt; no write.
  - 001110 BZ: read rs.
  - 001111 BEQ: read rs,rt.
  - 010000 JR: read rs.
  - 010001 HALT: no reads or writes.
  - Any other opcode issues as a NOP: no reads, no writes.
- Hazard: asserted when any read register or the write register has its pending bit set.
  - With WB_BYPASS=1, a register matching wb_rd_add while wb_valid=1 is treated as clear.
- id_ready = (state==RUN) && !hazard.
- Issue cycle (id_valid && id_ready): next edge sets ex_valid=1 and ex_op/ex_dst_add/ex_dst_wr.
  - Write-register pending bit is set on the same edge.
  - Otherwise ex_valid=0; the other ex_* outputs hold their last value.
- Writeback: wb_valid clears pending[wb_rd_add].
  - If writeback clear and issue set hit the same register in the same cycle, the set wins.
- States:
  - RUN: normal issue.
    - Issuing BZ, BEQ or JR -> BR_WAIT.
    - Issuing HALT -> HALTED.
  - BR_WAIT: exactly one cycle, id_ready=0.
    - Taken (ex_br_taken=1, or op was JR regardless of input) -> flush=1 on next edge, state -> FLUSH, counter=FLUSH_CYCLES-1.
    - Not taken -> RUN.
  - FLUSH: id_ready=0, flush=1 only on the entry edge; counter decrements each cycle; at 0 -> RUN.
  - HALTED: id_ready=0, halted=1; left only by reset.
    - Writebacks still clear pending bits in HALTED.
- Latency: ID-to-ex_valid is 1 cycle. Back-to-back independent instructions issue every cycle.

Optional Feature:
- Macro: ALU_ISSUE_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, all reset to 0, saturating at 32'hFFFFFFFF:
  - perf_issued: +1 per issue.
  - perf_stall: +1 per cycle with id_valid=1 and id_ready=0 in RUN.
  - perf_flush: +1 per flush pulse.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD r3=r1+r2 (op 000000, rd=3) -> ex_valid=1 next cycle, ex_dst_add=3, ex_dst_wr=1, pending[3]=1.
- Next instruction SUB reads r3 while pending[3]=1 -> id_ready=0 until wb_valid with wb_rd_add=3; with WB_BYPASS=1 it issues in that same cycle, with WB_BYPASS=0 one cycle later.
- BEQ with ex_br_taken=1 in BR_WAIT -> flush=1 for exactly one cycle, id_ready=0 for 1+FLUSH_CYCLES=3 cycles after the branch issues, then RUN.
- BZ with ex_br_taken=0 -> no flush, id_ready=1 two cycles after the branch issue cycle; JR with ex_br_taken=0 -> still flushes.
- Same-cycle wb_valid (wb_rd_add=5) and issue of ADDI writing r5 -> pending[5]=1 afterwards; HALT -> halted=1, id_ready=0 until reset.
- reset=0 asserted in BR_WAIT and in FLUSH -> next cycle state RUN, pending=0, flush=0, ex_valid=0; with ALU_ISSUE_PERF_CNT_EN defined, counters read 0.
